// File: rtl/axis_route_ctrl_dtu_pkg.sv
// Shared route types for the vFPGA host/DTU stream switch control.
// The route word layout and request FSM encoding are common to all blocks.
package lynxTypes;

  localparam int ROUTE_BITS = 8;
  localparam int DEST_BITS  = 3;

  typedef struct packed {
    logic [1:0]           rsvd;
    logic [DEST_BITS-1:0] dtu_dest;
    logic [DEST_BITS-1:0] host_dest;
  } route_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DRAIN = 2'd2,
    ST_APPLY = 2'd3
  } route_fsm_t;

  // Power-up routing: host sink i feeds DTU source i, DTU sink i feeds host source i.
  function automatic route_t reset_route(input int idx, input int n_id);
    route_t r;
    r.rsvd      = 2'b00;
    r.dtu_dest  = DEST_BITS'(idx);
    r.host_dest = DEST_BITS'(n_id + idx);
    return r;
  endfunction

  function automatic logic route_ok(input route_t r, input int n_id);
    return (r.rsvd == 2'b00) && (int'(r.host_dest) < 2 * n_id) && (int'(r.dtu_dest) < 2 * n_id);
  endfunction

endpackage

// File: rtl/axis_route_ctrl_dtu_pkt_tracker.sv
// Packet-in-flight tracker for one AXI4-Stream sink: busy between the first
// accepted non-last beat and the accepted tlast beat.
module axis_pkt_tracker (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tvalid_i,
  input  logic tready_i,
  input  logic tlast_i,
  output logic busy_o,
  output logic open_beat_o
);

  logic busy_q;
  logic busy_d;

  assign open_beat_o = tvalid_i & tready_i & ~tlast_i;
  assign busy_o      = busy_q;

  // Next busy state from the accepted beat, if any
  always_comb begin
    busy_d = busy_q;
    if (tvalid_i && tready_i) begin
      busy_d = ~tlast_i;
    end else begin
      busy_d = busy_q;
    end
  end

  // Busy flag register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/axis_route_ctrl_dtu.sv
// Route controller for the host/DTU stream switch; applies route updates only
// at packet boundaries. Optional counters: define AXIS_ROUTE_CTRL_STATS_EN.
module axis_route_ctrl_dtu
  import lynxTypes::*;
#(
  parameter int N_ID = 2
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [7:0]                 cfg_id,
  input  logic [ROUTE_BITS-1:0]      cfg_route,
  output logic                       cfg_done,
  output logic                       cfg_err,
  input  logic [N_ID-1:0]            host_tvalid,
  input  logic [N_ID-1:0]            host_tready,
  input  logic [N_ID-1:0]            host_tlast,
  input  logic [N_ID-1:0]            dtu_tvalid,
  input  logic [N_ID-1:0]            dtu_tready,
  input  logic [N_ID-1:0]            dtu_tlast,
  output logic [N_ID-1:0]            hold,
`ifdef AXIS_ROUTE_CTRL_STATS_EN
  output logic [N_ID*16-1:0]         stat_updates,
  output logic [N_ID*16-1:0]         stat_stall_cycles,
`endif
  output logic [N_ID*ROUTE_BITS-1:0] route_out
);

  route_fsm_t      state_q, state_d;
  logic [7:0]      id_q, id_d;
  route_t          rt_q, rt_d;
  route_t          route_q [N_ID];
  logic            done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic [N_ID-1:0] hold_q, hold_d;
  logic [N_ID-1:0] host_busy_s, dtu_busy_s, host_open_s, dtu_open_s;
  logic            sel_busy_s, sel_open_s, req_ok_s, upd_s;

  for (genvar g = 0; g < N_ID; g++) begin : g_region
    axis_pkt_tracker u_host (
      .clk_i(aclk), .rst_i(areset), .tvalid_i(host_tvalid[g]), .tready_i(host_tready[g]),
      .tlast_i(host_tlast[g]), .busy_o(host_busy_s[g]), .open_beat_o(host_open_s[g])
    );
    axis_pkt_tracker u_dtu (
      .clk_i(aclk), .rst_i(areset), .tvalid_i(dtu_tvalid[g]), .tready_i(dtu_tready[g]),
      .tlast_i(dtu_tlast[g]), .busy_o(dtu_busy_s[g]), .open_beat_o(dtu_open_s[g])
    );
    assign route_out[g*ROUTE_BITS +: ROUTE_BITS] = route_q[g];
  end

  // Packet activity of the region named by the pending request
  always_comb begin
    sel_busy_s = 1'b0;
    sel_open_s = 1'b0;
    for (int i = 0; i < N_ID; i++) begin
      sel_busy_s = sel_busy_s | ((id_q == 8'(i)) & (host_busy_s[i] | dtu_busy_s[i]));
      sel_open_s = sel_open_s | ((id_q == 8'(i)) & (host_open_s[i] | dtu_open_s[i]));
    end
    req_ok_s = (id_q < 8'(N_ID)) && route_ok(rt_q, N_ID);
  end

  // Request FSM next state and registered-output next values
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rt_d    = rt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    upd_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && ready_q) begin
          id_d    = cfg_id;
          rt_d    = route_t'(cfg_route);
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (req_ok_s) begin
          state_d = ST_DRAIN;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!sel_busy_s && !sel_open_s) begin
          done_d  = 1'b1;
          state_d = ST_APPLY;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_APPLY: begin
        upd_s   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // cfg_ready stays low through the completion pulse cycle
    ready_d = (state_d == ST_IDLE) && !done_d;
    for (int i = 0; i < N_ID; i++) begin
      hold_d[i] = ((state_d == ST_DRAIN) || (state_d == ST_APPLY)) && (id_d == 8'(i));
    end
  end

  // FSM, request slot and handshake output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      id_q    <= 8'd0;
      rt_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rt_q    <= rt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
    end
  end

  // Route word registers; only the requested region is ever written
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_ID; i++) route_q[i] <= reset_route(i, N_ID);
    end else begin
      for (int i = 0; i < N_ID; i++) begin
        if (upd_s && (id_q == 8'(i))) route_q[i] <= rt_q;
      end
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign hold      = hold_q;

`ifdef AXIS_ROUTE_CTRL_STATS_EN
  logic [15:0] upd_cnt_q   [N_ID];
  logic [15:0] stall_cnt_q [N_ID];

  // Saturating per-region update and drain-stall counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_ID; i++) begin
        upd_cnt_q[i]   <= 16'd0;
        stall_cnt_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < N_ID; i++) begin
        if (upd_s && (id_q == 8'(i)) && (upd_cnt_q[i] != 16'hFFFF))
          upd_cnt_q[i] <= upd_cnt_q[i] + 16'd1;
        if ((state_q == ST_DRAIN) && (id_q == 8'(i)) && (stall_cnt_q[i] != 16'hFFFF))
          stall_cnt_q[i] <= stall_cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_ID; g++) begin : g_stats
    assign stat_updates[g*16 +: 16]      = upd_cnt_q[g];
    assign stat_stall_cycles[g*16 +: 16] = stall_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axis_route_ctrl_dtu.sv
// Self-checking bench for axis_route_ctrl_dtu (N_ID=2): directed scenarios then
// randomized traffic and requests against an event-time reference model.
module tb_axis_route_ctrl_dtu;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_valid, cfg_ready, cfg_done, cfg_err;
  logic [7:0]  cfg_id, cfg_route;
  logic [1:0]  host_tvalid, host_tready, host_tlast;
  logic [1:0]  dtu_tvalid, dtu_tready, dtu_tlast;
  logic [1:0]  hold;
  logic [15:0] route_out;
`ifdef AXIS_ROUTE_CTRL_STATS_EN
  logic [31:0] stat_updates, stat_stall_cycles;
`endif

  axis_route_ctrl_dtu #(.N_ID(2)) dut (
    .aclk(aclk), .areset(areset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_id(cfg_id), .cfg_route(cfg_route), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .host_tvalid(host_tvalid), .host_tready(host_tready), .host_tlast(host_tlast),
    .dtu_tvalid(dtu_tvalid), .dtu_tready(dtu_tready), .dtu_tlast(dtu_tlast),
    .hold(hold),
`ifdef AXIS_ROUTE_CTRL_STATS_EN
    .stat_updates(stat_updates), .stat_stall_cycles(stat_stall_cycles),
`endif
    .route_out(route_out)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Reference model: packet-open flags, expected routes, one pending request
  // described by its accept edge and the edge at which the region went quiet.
  bit         open_h [2];
  bit         open_d [2];
  logic [7:0] exp_route [2];
  logic       exp_ready, exp_done, exp_err;
  logic [1:0] exp_hold;
  int         edge_n, acc_e, drn_e, rid;
  bit         pend, pend_ok;
  logic [7:0] rrt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("route_out", {16'd0, route_out}, {16'd0, exp_route[1], exp_route[0]});
    chk("hold", {30'd0, hold}, {30'd0, exp_hold});
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_ready});
    chk("cfg_done", {31'd0, cfg_done}, {31'd0, exp_done});
    chk("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      open_h[i] = 1'b0;
      open_d[i] = 1'b0;
    end
    exp_route[0] = 8'h02;
    exp_route[1] = 8'h0B;
    exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0; exp_hold = 2'b00;
    pend = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #2;
    model_reset();
    chk_all();
    areset = 1'b0;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_id = 8'd0; cfg_route = 8'd0;
    host_tvalid = 2'b00; host_tready = 2'b00; host_tlast = 2'b00;
    dtu_tvalid = 2'b00; dtu_tready = 2'b00; dtu_tlast = 2'b00;
  endtask

  // One clock: evaluate the cycle's inputs, advance, predict, compare.
  task automatic tick();
    bit q [2];
    bit acc;
    for (int i = 0; i < 2; i++) begin
      q[i] = !open_h[i] && !open_d[i]
             && !(host_tvalid[i] && host_tready[i] && !host_tlast[i])
             && !(dtu_tvalid[i] && dtu_tready[i] && !dtu_tlast[i]);
    end
    acc = cfg_valid && exp_ready;
    @(posedge aclk);
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (host_tvalid[i] && host_tready[i]) open_h[i] = !host_tlast[i];
      if (dtu_tvalid[i] && dtu_tready[i]) open_d[i] = !dtu_tlast[i];
    end
    if (acc) begin
      pend    = 1'b1;
      acc_e   = edge_n;
      rid     = int'(cfg_id);
      rrt     = cfg_route;
      pend_ok = (cfg_id < 8'd2) && (cfg_route[7:6] == 2'b00)
                && (cfg_route[2:0] < 3'd4) && (cfg_route[5:3] < 3'd4);
      drn_e   = -1;
    end
    exp_done = 1'b0; exp_err = 1'b0; exp_hold = 2'b00; exp_ready = 1'b1;
    if (pend) begin
      if (pend_ok) begin
        if (drn_e < 0 && edge_n >= acc_e + 2 && q[rid]) drn_e = edge_n;
        if (drn_e >= 0 && edge_n == drn_e + 1) begin
          exp_route[rid] = rrt;
          pend = 1'b0;
        end else begin
          exp_ready     = 1'b0;
          exp_hold[rid] = (edge_n >= acc_e + 1);
          exp_done      = (edge_n == drn_e);
        end
      end else begin
        if (edge_n == acc_e + 2) begin
          pend = 1'b0;
        end else begin
          exp_ready = 1'b0;
          exp_done  = (edge_n == acc_e + 1);
          exp_err   = exp_done;
        end
      end
    end
    #1;
    chk_all();
  endtask

  task automatic request(input logic [7:0] id, input logic [7:0] rt, input int cycles);
    cfg_valid = 1'b1; cfg_id = id; cfg_route = rt;
    tick();
    cfg_valid = 1'b0;
    repeat (cycles) tick();
  endtask

  initial begin
    logic [7:0] inv_id [3];
    logic [7:0] inv_rt [3];
    logic [7:0] r;
    edge_n = 0;
    idle_inputs();
    #1;
    do_reset();
    chk("reset_routes", {16'd0, route_out}, 32'h0000_0B02);

    // Idle region update with minimum latency
    request(8'd0, 8'h19, 4);
    chk("idle_update_r0", {24'd0, route_out[7:0]}, 32'h19);
    chk("idle_update_r1", {24'd0, route_out[15:8]}, 32'h0B);

    // Request while a 4-beat host packet is in flight on region 1
    host_tvalid = 2'b10; host_tready = 2'b10; host_tlast = 2'b00;
    tick(); tick();
    host_tvalid = 2'b00;
    request(8'd1, 8'h08, 2);
    host_tvalid = 2'b10;
    tick();
    host_tlast = 2'b10;
    tick();
    host_tvalid = 2'b00; host_tlast = 2'b00; host_tready = 2'b00;
    repeat (4) tick();
    chk("drain_update_r1", {24'd0, route_out[15:8]}, 32'h08);

    // Invalid requests: bad id, out-of-range host dest, reserved bits set
    inv_id[0] = 8'd2; inv_rt[0] = 8'h09;
    inv_id[1] = 8'd0; inv_rt[1] = 8'h04;
    inv_id[2] = 8'd1; inv_rt[2] = 8'h40;
    for (int k = 0; k < 3; k++) request(inv_id[k], inv_rt[k], 3);

    // cfg_valid held high across two back-to-back requests
    cfg_valid = 1'b1; cfg_id = 8'd0; cfg_route = 8'h0A;
    tick();
    cfg_id = 8'd1; cfg_route = 8'h03;
    repeat (9) tick();
    cfg_valid = 1'b0;
    repeat (2) tick();

    // Reset while draining, then a fresh request completes
    host_tvalid = 2'b01; host_tready = 2'b01; host_tlast = 2'b00;
    tick();
    host_tvalid = 2'b00;
    request(8'd0, 8'h11, 4);
    host_tready = 2'b00;
    do_reset();
    chk("mid_reset_routes", {16'd0, route_out}, 32'h0000_0B02);
    request(8'd1, 8'h1A, 4);
    chk("post_reset_r1", {24'd0, route_out[15:8]}, 32'h1A);

    // Randomized traffic and requests
    for (int n = 0; n < 400; n++) begin
      host_tvalid = 2'($urandom); host_tready = 2'($urandom);
      host_tlast  = 2'($urandom) & 2'($urandom);
      dtu_tvalid  = 2'($urandom); dtu_tready  = 2'($urandom);
      dtu_tlast   = 2'($urandom) | 2'($urandom);
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_id      = 8'($urandom_range(0, 2));
      r[7:6]      = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      r[5:3]      = 3'($urandom_range(0, 4));
      r[2:0]      = 3'($urandom_range(0, 4));
      cfg_route   = r;
      tick();
    end
    idle_inputs();
    host_tvalid = 2'b11; host_tready = 2'b11; host_tlast = 2'b11;
    dtu_tvalid  = 2'b11; dtu_tready  = 2'b11; dtu_tlast  = 2'b11;
    tick();
    idle_inputs();
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_route_ctrl_dtu.md
Name: axis_route_ctrl_dtu

Overview:
- Drives the per-region `route` vector consumed by the vFPGA host/DTU AXI4-Stream data switch.
- Accepts route-update requests over a valid/ready config channel and validates them.
- Monitors each region's host-sink and DTU-sink stream handshakes, and applies a new route only at a packet boundary so no packet is split across destinations.
- Sits between the control/CSR logic and the data switch.

Parameters:
- N_ID, N_REGIONS: number of vFPGA regions (1..4).
- DEST_BITS, 3: width of one tdest field.
- ROUTE_BITS, 8: width of one route word.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  route update request valid
- cfg_ready  out  1  request accepted when cfg_valid&&cfg_ready
- cfg_id  in  8  target region index
- cfg_route  in  ROUTE_BITS  new route: [2:0] host-sink tdest, [5:3] DTU-sink tdest, [7:6] reserved (must be 0)
- cfg_done  out  1  one-cycle completion pulse
- cfg_err  out  1  valid with cfg_done; 1 = request rejected
- host_tvalid, host_tready, host_tlast  in  N_ID each  host-sink handshake monitor
- dtu_tvalid, dtu_tready, dtu_tlast  in  N_ID each  DTU-sink handshake monitor
- hold  out  N_ID  per region: upstream must not start a new packet
- route_out  out  N_ID x ROUTE_BITS  route words to the switch

Behaviour:
- Reset value of route_out[i]: {2'b00, i[2:0], (N_ID+i)[2:0]}. Host sink i routes to DTU source i; DTU sink i routes to host source i.
- Reset values of other outputs: hold=0, cfg_done=0, cfg_err=0, cfg_ready=1, FSM=IDLE, all busy flags 0.
- Busy tracking, per region and per stream:
  - host_busy[i] sets on a beat with tvalid&&tready&&!tlast.
  - host_busy[i] clears on a beat with tvalid&&tready&&tlast.
  - dtu_busy[i] follows the same rule on the DTU-sink signals.
  - Single-beat packets (tlast on the first beat) leave busy at 0.
- FSM: IDLE, CHECK, DRAIN, APPLY. A single global request slot.
  - IDLE: cfg_ready=1. On accept, latch id and route, then go to CHECK.
  - CHECK: cfg_ready=0. The request is invalid if any of these holds: id>=N_ID; route[2:0]>=2*N_ID; route[5:3]>=2*N_ID; route[7:6]!=0.
    - Invalid: pulse cfg_done=1 and cfg_err=1, route unchanged, go to IDLE.
    - Valid: go to DRAIN.
  - DRAIN: hold[id]=1, all other hold bits 0. Go to APPLY when host_busy[id]==0 and dtu_busy[id]==0 at the cycle start, and no non-last beat of region id is accepted in the same cycle.
  - APPLY: route_out[id] <= latched route at the end of this cycle; pulse cfg_done=1, cfg_err=0; hold[id] stays 1 this cycle; go to IDLE.
- Minimum latency: accept at edge 0; route_out is updated at edge 3; cfg_done is high in the cycle after edge 2.
- A new request is accepted in the cycle after cfg_done.
- A request whose route equals the current route still runs the full sequence and returns cfg_err=0.
- Beats accepted while hold is asserted are still tracked. hold is advisory and the block does not gate tvalid.
- There is no timeout: DRAIN waits indefinitely.
- areset mid-operation: asynchronously returns all state and outputs to reset values. A pending request is dropped with no cfg_done.
- The route_out registers of regions other than id never change during a request.

Optional Feature:
- Macro: AXIS_ROUTE_CTRL_STATS_EN.
- When defined:
  - Adds outputs stat_updates (N_ID x 16) and stat_stall_cycles (N_ID x 16).
  - stat_updates[i] increments on each APPLY for region i.
  - stat_stall_cycles[i] increments on each cycle in DRAIN for region i.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package lynxTypes holds:
  - the route_t typedef (packed struct: rsvd[1:0], dtu_dest[2:0], host_dest[2:0]);
  - the ROUTE_BITS and DEST_BITS constants;
  - the route_fsm_t enum.
- Sub-module axis_pkt_tracker: one instance per region per stream. It produces the busy flag from tvalid/tready/tlast.

Test Plan:
- Reset with N_ID=2: route_out[0]=8'h02, route_out[1]=8'h0B; hold=0; cfg_ready=1.
- Idle region, cfg_id=0, cfg_route=8'h19: route_out[0]=8'h19 at edge 3; cfg_done=1, cfg_err=0; route_out[1] unchanged.
- Host packet of 4 beats in flight on region 1 (beat 2 accepted), request cfg_id=1, cfg_route=8'h08:
  - hold[1]=1 until the tlast beat;
  - route_out[1] updates 2 cycles after the tlast beat;
  - no beat of the packet is observed after the route change.
- Invalid requests (cfg_id=2 with N_ID=2; route 8'h04 with N_ID=2; route 8'h40): each gives cfg_done=1 and cfg_err=1 two cycles after accept, with route_out unchanged.
- cfg_valid held high continuously: cfg_ready is low from edge 1 until cfg_done; the second request is accepted in the cycle after cfg_done.
- areset pulsed during DRAIN: all route_out return to reset values; hold=0; no cfg_done; a new request then completes normally.
